// File: rtl/lcd_bus_arbiter.sv
// Round-robin two-requester arbiter and E-strobe sequencer for an HD44780 bus.
// Define LCD_ARB_INIT_EN to add the power-up wait and built-in init sequence.
module lcd_bus_arbiter #(
  parameter int T_SETUP     = 2,
  parameter int T_PW        = 4,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 8,
  parameter int T_EXEC_LONG = 32,
  parameter int T_POWERUP   = 16,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       req_rs0,
  input  logic       req_rs1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    HOLD    = 3'd3,
    EXEC    = 3'd4
`ifdef LCD_ARB_INIT_EN
    ,
    POWERUP = 3'd5,
    INIT    = 3'd6
`endif
  } state_t;

`ifdef LCD_ARB_INIT_EN
  localparam bit     INIT_EN   = 1'b1;
  localparam state_t RST_STATE = POWERUP;
`else
  localparam bit     INIT_EN   = 1'b0;
  localparam state_t RST_STATE = IDLE;
`endif

  localparam logic [CNT_W-1:0] RST_CNT =
    INIT_EN ? CNT_W'(T_POWERUP - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             gnt;
  logic             cnt_done;
  logic             long_cmd;

  assign busy     = (state != IDLE);
  assign cnt_done = (cnt == '0);

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_cmd = !lcd_rs &&
    (lcd_data == 8'h01 ||
     lcd_data == 8'h02 ||
     lcd_data == 8'h03);

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt = ~last;
      (req == 2'b10): gnt = 1'b1;
      default:        gnt = 1'b0;
    endcase
  end

`ifdef LCD_ARB_INIT_EN
  logic [1:0] init_idx;
  logic       init_run;
  logic [7:0] init_byte;

  always_comb begin
    init_byte = 8'h01;
    unique case (init_idx)
      2'd0:    init_byte = 8'h3C;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RST_STATE;
      cnt      <= RST_CNT;
      last     <= 1'b1;
      ack      <= 2'b00;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_data <= 8'h00;
`ifdef LCD_ARB_INIT_EN
      init_idx <= 2'd0;
      init_run <= 1'b1;
`endif
    end else begin
      ack <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|req) begin
            lcd_rs   <= gnt ? req_rs1 : req_rs0;
            lcd_data <= gnt ? req_data1 : req_data0;
            ack      <= gnt ? 2'b10 : 2'b01;
            last     <= gnt;
            cnt      <= CNT_W'(T_SETUP - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            lcd_e <= 1'b1;
            cnt   <= CNT_W'(T_PW - 1);
            state <= PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_done) begin
            lcd_e <= 1'b0;
            cnt   <= CNT_W'(T_HOLD - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cnt   <= long_cmd ? CNT_W'(T_EXEC_LONG - 1)
                              : CNT_W'(T_EXEC - 1);
            state <= EXEC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        EXEC: begin
          if (cnt_done) begin
`ifdef LCD_ARB_INIT_EN
            if (init_run) begin
              if (init_idx == 2'd3) begin
                init_run <= 1'b0;
                state    <= IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                state    <= INIT;
              end
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef LCD_ARB_INIT_EN
        POWERUP: begin
          if (cnt_done) begin
            state <= INIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        INIT: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_byte;
          cnt      <= CNT_W'(T_SETUP - 1);
          state    <= SETUP;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Arbitrated sequencer for the HD44780-style character LCD bus. Two requesters, e.g. a text-line writer and a status/cursor updater, submit single register writes (RS plus 8-bit data) over a req/ack handshake. The block grants one requester at a time with round-robin priority and generates the E-strobe setup, pulse and hold timing. It then waits out the command execution time, so requesters never touch `lcd_e`/`lcd_rs`/`lcd_rw`/`lcd_data` directly.

## Interface
- `T_SETUP`, 2: clock cycles RS/DATA are stable before E rises (≥1)
- `T_PW`, 4: clock cycles E is high (≥1)
- `T_HOLD`, 2: clock cycles RS/DATA are held after E falls (≥1)
- `T_EXEC`, 8: execution wait for normal writes (≥1)
- `T_EXEC_LONG`, 32: execution wait for clear/home commands (≥1)
- `T_POWERUP`, 16: power-on wait before the init sequence (used only with the macro)
- `CNT_W`, 20: width of the shared delay counter; must hold the largest T_* value

- `clk` input 1: system clock
- `rst` input 1: asynchronous, active-low reset
- `req` input 2: per-requester write request, held until ack
- `req_rs0`, `req_rs1` input 1: RS for requester 0/1 (0 = command, 1 = data)
- `req_data0`, `req_data1` input 8: byte for requester 0/1
- `ack` output 2: one-cycle grant/accept pulse per requester
- `busy` output 1: high whenever the state is not IDLE
- `lcd_e`, `lcd_rs`, `lcd_rw` output 1: LCD bus control
- `lcd_data` output 8: LCD bus data

## Operation
- States: POWERUP, INIT, IDLE, SETUP, PULSE, HOLD, EXEC.
- All outputs are registered except `busy`, which is decoded from the state.
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `ack`=0, round-robin pointer `last`=1. The reset state is IDLE, or POWERUP when the macro is defined.
- `lcd_rw` is always 0. The block only writes to the LCD.
- IDLE behaviour:
  - If any `req` bit is set, grant one requester.
  - Single request: grant that requester.
  - Both requesting: grant the requester other than `last`, so requester 0 wins the first tie after reset.
  - On the grant edge: latch the granted RS/data onto `lcd_rs`/`lcd_data`, pulse `ack[g]` for one cycle, set `last`=g, and go to SETUP.
- SETUP lasts T_SETUP cycles with E=0. PULSE lasts T_PW cycles with E=1. HOLD lasts T_HOLD cycles with E=0. EXEC lasts T_EXEC cycles, or T_EXEC_LONG when RS=0 and data is 0x01, 0x02 or 0x03. The block then returns to IDLE.
- `lcd_rs`/`lcd_data` hold their values from the grant edge until the next grant.
- A requester drops `req` in the cycle `ack` is seen. A `req` still high when IDLE is next reached counts as a new request.
- Request inputs are ignored outside IDLE. No request is lost; it waits in `req`.
- Reset mid-transfer: the transfer is abandoned immediately, outputs take their reset values, and no ack is issued for it.

## Timing
- Grant edge G: `ack` is high during cycle G..G+1.
- E rises at edge G+T_SETUP and falls at G+T_SETUP+T_PW.
- IDLE is re-entered at G+T_SETUP+T_PW+T_HOLD+T_EXEC (or +T_EXEC_LONG).
- Minimum spacing between grants is T_SETUP+T_PW+T_HOLD+T_EXEC+1 cycles (17 with the defaults).
- E-high width is exactly T_PW cycles. There is no E glitch on grant or reset.

## Configuration
- `LCD_ARB_INIT_EN` defined:
  - Reset enters POWERUP and waits T_POWERUP cycles.
  - INIT then issues commands 0x3C (function set), 0x0C (display on), 0x06 (entry mode) and 0x01 (clear), with RS=0, through the same SETUP/PULSE/HOLD/EXEC path. The clear uses T_EXEC_LONG. No ack is issued for these.
  - The block then enters IDLE.
  - `busy`=1 throughout, and requests stay pending.
- Not defined: POWERUP and INIT are absent, reset enters IDLE, and `busy`=0 after reset.

## Test plan
- Single write (default params, macro off): req=01, rs0=1, data0=0x48 → `ack`=01 for 1 cycle, `lcd_rs`=1, `lcd_data`=0x48. E is high for exactly 4 cycles starting 2 cycles after the grant. `busy` falls 16 cycles after the grant.
- Long command: requester 1 sends RS=0, 0x01 → EXEC lasts 32 cycles and IDLE is reached 40 cycles after the grant. Repeat with 0x06 → 16 cycles.
- Contention: req=11 held continuously with distinct bytes 0xAA/0x55 → grants alternate 0,1,0,1, each 17 cycles apart. `lcd_data` alternates 0xAA/0x55.
- Reset mid-PULSE: assert `rst`=0 while `lcd_e`=1 → `lcd_e`, `lcd_rs` and `lcd_data` go to 0 immediately with no ack. After release, the pending req is granted 1 cycle later.
- Init (macro on): after reset, `busy`=1, the bus idles 16 cycles, then four E pulses with data 0x3C, 0x0C, 0x06, 0x01 and RS=0. A req held from reset is acked only after the 0x01 EXEC completes.
